// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue stage: op codes, rounding modes, fflags layout,
// CSR selectors and issue FSM encoding.
package fpu_pkg;

   localparam logic [4:0] OP_FADD     = 5'b00000;
   localparam logic [4:0] OP_FSUB     = 5'b00001;
   localparam logic [4:0] OP_FMUL     = 5'b00010;
   localparam logic [4:0] OP_FDIV     = 5'b00011;
   localparam logic [4:0] OP_FSGNJ    = 5'b00100;
   localparam logic [4:0] OP_FMINMAX  = 5'b00101;
   localparam logic [4:0] OP_FSQRT    = 5'b01011;
   localparam logic [4:0] OP_FCMP     = 5'b10100;
   localparam logic [4:0] OP_FCVT_W_S = 5'b11000;
   localparam logic [4:0] OP_FCVT_S_W = 5'b11010;
   localparam logic [4:0] OP_FMV_W_X  = 5'b11110;
   localparam logic [4:0] OP_FCLASS   = 5'b11100;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int FF_NX = 0;
   localparam int FF_UF = 1;
   localparam int FF_OF = 2;
   localparam int FF_DZ = 3;
   localparam int FF_NV = 4;

   localparam logic [1:0] CSR_FFLAGS = 2'b00;
   localparam logic [1:0] CSR_FRM    = 2'b01;
   localparam logic [1:0] CSR_FCSR   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_WB   = 2'b10
   } issue_state_t;

   // Only these ops consume a rounding mode; the rest use the field as a funct3 selector.
   function automatic logic is_rounding_op(input logic [4:0] op);
      case (op)
         OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
         OP_FSQRT, OP_FCVT_W_S, OP_FCVT_S_W: is_rounding_op = 1'b1;
         default:                            is_rounding_op = 1'b0;
      endcase
   endfunction

   function automatic logic rm_is_illegal(input logic [2:0] rm);
      rm_is_illegal = (rm > RM_RMM);
   endfunction

endpackage

// File: rtl/fpu_csr_regs.sv
// Floating-point CSR state (frm, fflags). A software write to a field takes priority
// over flag accrual from a completing op in the same cycle.
module fpu_csr_regs
   import fpu_pkg::*;
#(
   parameter logic [2:0] FRM_RESET = RM_RNE
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_csr_we,
   input  logic [1:0] i_csr_sel,
   input  logic [7:0] i_csr_wdata,
   input  logic       i_acc_en,
   input  logic [4:0] i_acc_flags,
   output logic [2:0] o_frm,
   output logic [7:0] o_fcsr
);

   logic [2:0] r_frm;
   logic [4:0] r_fflags;
   logic       w_wr_flags;
   logic       w_wr_frm;
   logic [2:0] w_frm_wdata;

   assign w_wr_flags  = i_csr_we && ((i_csr_sel == CSR_FFLAGS) || (i_csr_sel == CSR_FCSR));
   assign w_wr_frm    = i_csr_we && ((i_csr_sel == CSR_FRM) || (i_csr_sel == CSR_FCSR));
   assign w_frm_wdata = (i_csr_sel == CSR_FCSR) ? i_csr_wdata[7:5] : i_csr_wdata[2:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frm    <= FRM_RESET;
         r_fflags <= '0;
      end else begin
         if (w_wr_frm)
            r_frm <= w_frm_wdata;
         if (w_wr_flags)
            r_fflags <= i_csr_wdata[4:0];
         else if (i_acc_en)
            r_fflags <= r_fflags | i_acc_flags;
      end
   end

   assign o_frm  = r_frm;
   assign o_fcsr = {r_frm, r_fflags};

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing stage in front of the FPU arithmetic unit: accepts one request,
// resolves dynamic rounding, holds operands until done, then hands the result to writeback.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter logic [2:0] FRM_RESET = 3'b000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4:0]      req_op,
   input  logic [2:0]      req_rm,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            req_rs2_lsb,
   input  logic [4:0]      req_rd,
   output logic            fpu_start,
   output logic [4:0]      fpu_op,
   output logic [2:0]      fpu_rm,
   output logic [XLEN-1:0] fpu_a,
   output logic [XLEN-1:0] fpu_b,
   output logic            fpu_rs2_lsb,
   input  logic [XLEN-1:0] fpu_result,
   input  logic            fpu_done,
   input  logic [4:0]      fpu_flags,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            illegal_rm,
   input  logic            csr_we,
   input  logic [1:0]      csr_sel,
   input  logic [7:0]      csr_wdata,
   output logic [7:0]      fcsr_out
);

   issue_state_t    r_state;
   logic            r_req_ready;
   logic            r_start;
   logic            r_wb_valid;
   logic            r_illegal_rm;
   logic [4:0]      r_op;
   logic [2:0]      r_rm;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic            r_rs2_lsb;
   logic [XLEN-1:0] r_wb_data;
   logic [4:0]      r_wb_rd;

   logic [2:0]      w_frm;
   logic            w_is_rnd;
   logic [2:0]      w_rm_res;
   logic            w_bad_rm;
   logic            w_capture;

   // frm is sampled only here, at acceptance, so an in-flight op keeps its latched mode.
   assign w_is_rnd  = is_rounding_op(req_op);
   assign w_rm_res  = (w_is_rnd && (req_rm == RM_DYN)) ? w_frm : req_rm;
   assign w_bad_rm  = w_is_rnd && rm_is_illegal(w_rm_res);
   assign w_capture = (r_state == ST_BUSY) && fpu_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_start      <= 1'b0;
         r_wb_valid   <= 1'b0;
         r_illegal_rm <= 1'b0;
         r_op         <= '0;
         r_rm         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_rs2_lsb    <= 1'b0;
         r_wb_data    <= '0;
         r_wb_rd      <= '0;
      end else begin
         r_illegal_rm <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_op      <= req_op;
                  r_rm      <= w_rm_res;
                  r_a       <= req_a;
                  r_b       <= req_b;
                  r_rs2_lsb <= req_rs2_lsb;
                  r_wb_rd   <= req_rd;
                  if (w_bad_rm) begin
                     r_illegal_rm <= 1'b1;
                  end else begin
                     r_state     <= ST_BUSY;
                     r_start     <= 1'b1;
                     r_req_ready <= 1'b0;
                  end
               end
            end
            ST_BUSY: begin
               if (fpu_done) begin
                  r_wb_data  <= fpu_result;
                  r_start    <= 1'b0;
                  r_wb_valid <= 1'b1;
                  r_state    <= ST_WB;
               end
            end
            ST_WB: begin
               if (wb_ready) begin
                  r_wb_valid  <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_start     <= 1'b0;
               r_wb_valid  <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   fpu_csr_regs #(
      .FRM_RESET (FRM_RESET)
   ) u_csr (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_csr_we    (csr_we),
      .i_csr_sel   (csr_sel),
      .i_csr_wdata (csr_wdata),
      .i_acc_en    (w_capture),
      .i_acc_flags (fpu_flags),
      .o_frm       (w_frm),
      .o_fcsr      (fcsr_out)
   );

   assign req_ready   = r_req_ready;
   assign fpu_start   = r_start;
   assign fpu_op      = r_op;
   assign fpu_rm      = r_rm;
   assign fpu_a       = r_a;
   assign fpu_b       = r_b;
   assign fpu_rs2_lsb = r_rs2_lsb;
   assign wb_valid    = r_wb_valid;
   assign wb_data     = r_wb_data;
   assign wb_rd       = r_wb_rd;
   assign illegal_rm  = r_illegal_rm;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: stub arithmetic unit with programmable latency, writeback
// scoreboard, and directed checks on timing, rounding resolution, flags and reset.
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid, req_ready;
   logic [4:0]      req_op;
   logic [2:0]      req_rm;
   logic [XLEN-1:0] req_a, req_b;
   logic            req_rs2_lsb;
   logic [4:0]      req_rd;
   logic            fpu_start;
   logic [4:0]      fpu_op;
   logic [2:0]      fpu_rm;
   logic [XLEN-1:0] fpu_a, fpu_b;
   logic            fpu_rs2_lsb;
   logic [XLEN-1:0] fpu_result;
   logic            fpu_done;
   logic [4:0]      fpu_flags;
   logic            wb_valid, wb_ready;
   logic [XLEN-1:0] wb_data;
   logic [4:0]      wb_rd;
   logic            illegal_rm;
   logic            csr_we;
   logic [1:0]      csr_sel;
   logic [7:0]      csr_wdata;
   logic [7:0]      fcsr_out;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.XLEN(XLEN), .FRM_RESET(3'b000)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
      .req_a(req_a), .req_b(req_b), .req_rs2_lsb(req_rs2_lsb), .req_rd(req_rd),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_rs2_lsb(fpu_rs2_lsb), .fpu_result(fpu_result), .fpu_done(fpu_done),
      .fpu_flags(fpu_flags), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .illegal_rm(illegal_rm), .csr_we(csr_we), .csr_sel(csr_sel),
      .csr_wdata(csr_wdata), .fcsr_out(fcsr_out)
   );

   // Stub arithmetic unit: done after stub_lat extra cycles of fpu_start.
   logic [31:0] stub_res;
   logic [4:0]  stub_fl;
   int          stub_lat;
   int          busy_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) busy_cnt <= 0;
      else       busy_cnt <= fpu_start ? busy_cnt + 1 : 0;
   end

   assign fpu_done   = fpu_start && (busy_cnt == stub_lat);
   assign fpu_result = stub_res;
   assign fpu_flags  = fpu_done ? stub_fl : 5'd0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t sb_q[$];
   int  checks = 0;
   int  fails  = 0;
   int  hs_cnt = 0;
   int  acc_wait;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && wb_valid && wb_ready) begin
         wb_t e;
         hs_cnt++;
         chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
         end
      end
   end

   task automatic send(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                       input logic [4:0] fl, input int lat, input logic [2:0] exp_rm);
      int n = 0;
      @(posedge clk); #1;
      stub_res = res; stub_fl = fl; stub_lat = lat;
      req_op = op; req_rm = rm; req_a = a; req_b = b; req_rd = rd;
      req_rs2_lsb = 1'b1; req_valid = 1'b1;
      sb_q.push_back({rd, res});
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      chk("accept", 32'(req_ready), 32'd1);
      acc_wait = n;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("start", 32'(fpu_start), 32'd1);
      chk("fpu_op", 32'(fpu_op), 32'(op));
      chk("fpu_rm", 32'(fpu_rm), 32'(exp_rm));
      chk("fpu_a", fpu_a, a);
      chk("fpu_b", fpu_b, b);
      chk("busy_not_ready", 32'(req_ready), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || wb_valid) && n < 200) begin @(negedge clk); n++; end
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic csr_wr(input logic [1:0] sel, input logic [7:0] d);
      @(posedge clk); #1 csr_we = 1'b1; csr_sel = sel; csr_wdata = d;
      @(posedge clk); #1 csr_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_bad(input logic [4:0] op, input logic [2:0] rm, input logic [7:0] exp_fcsr);
      int hs0 = hs_cnt;
      int seen = 0;
      @(posedge clk); #1 req_op = op; req_rm = rm; req_rd = 5'd9; req_valid = 1'b1;
      @(negedge clk); chk("bad_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("illegal_pulse", 32'(illegal_rm), 32'd1);
      chk("bad_no_start", 32'(fpu_start), 32'd0);
      chk("bad_still_ready", 32'(req_ready), 32'd1);
      @(negedge clk); chk("illegal_one_cycle", 32'(illegal_rm), 32'd0);
      repeat (4) begin
         if (fpu_start || wb_valid) seen++;
         @(negedge clk);
      end
      chk("bad_quiet", 32'(seen), 32'd0);
      chk("bad_no_wb", 32'(hs_cnt - hs0), 32'd0);
      chk("bad_fcsr", 32'(fcsr_out), 32'(exp_fcsr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs0;
      logic [4:0] f_dz, f_nx;
      f_dz = '0; f_dz[FF_DZ] = 1'b1;
      f_nx = '0; f_nx[FF_NX] = 1'b1;

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
      req_rs2_lsb = 1'b0; req_rd = '0; wb_ready = 1'b1; csr_we = 1'b0; csr_sel = '0;
      csr_wdata = '0; stub_res = '0; stub_fl = '0; stub_lat = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_start", 32'(fpu_start), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_illegal", 32'(illegal_rm), 32'd0);
      chk("rst_fcsr", 32'(fcsr_out), 32'h00);
      chk("rst_fpu_a", fpu_a, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);

      // FADD 1.0 + 2.0, single-cycle op: start at T+1, wb_valid at T+2
      send(OP_FADD, RM_RNE, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 5'd0, 0, RM_RNE);
      @(negedge clk);
      chk("fadd_wb_valid_t2", 32'(wb_valid), 32'd1);
      chk("fadd_wb_data", wb_data, 32'h4040_0000);
      chk("fadd_fflags", 32'(fcsr_out[4:0]), 32'd0);
      drain();

      // FDIV 1.0/0.0 -> +inf, DZ; next request accepted without stall
      send(OP_FDIV, RM_RNE, 32'h3F80_0000, 32'h0, 5'd6, 32'h7F80_0000, f_dz, 3, RM_RNE);
      chk("accept_lat", 32'(acc_wait), 32'd0);
      drain();
      chk("fdiv_dz", 32'(fcsr_out[4:0]), 32'(f_dz));
      send(OP_FADD, RM_RNE, 32'h1, 32'h2, 5'd7, 32'h3, 5'd0, 1, RM_RNE);
      drain();
      chk("dz_sticky", 32'(fcsr_out[4:0]), 32'(f_dz));
      send(OP_FMUL, RM_RTZ, 32'h4, 32'h5, 5'd8, 32'h6, f_nx, 0, RM_RTZ);
      drain();
      chk("flags_accrue", 32'(fcsr_out[4:0]), 32'(f_dz | f_nx));

      // dynamic rounding from frm; frm change mid-op does not affect the latched rm
      csr_wr(CSR_FFLAGS, 8'h00);
      csr_wr(CSR_FRM, 8'h01);
      chk("frm_write", 32'(fcsr_out), 32'h20);
      send(OP_FMUL, RM_DYN, 32'h10, 32'h11, 5'd10, 32'h12, 5'd0, 4, RM_RTZ);
      csr_wr(CSR_FRM, 8'h04);
      chk("inflight_rm", 32'(fpu_rm), 32'(RM_RTZ));
      chk("inflight_start", 32'(fpu_start), 32'd1);
      drain();
      chk("frm_new", 32'(fcsr_out[7:5]), 32'(RM_RMM));
      send(OP_FCMP, RM_RDN, 32'h20, 32'h20, 5'd11, 32'h1, 5'd0, 0, RM_RDN);
      drain();

      // fcsr write sets frm=101 (reserved): dynamic-rm op is dropped
      csr_wr(CSR_FCSR, 8'hA3);
      chk("fcsr_write", 32'(fcsr_out), 32'hA3);
      send_bad(OP_FADD, RM_DYN, 8'hA3);
      csr_wr(CSR_FCSR, 8'h00);
      send_bad(OP_FSQRT, 3'b110, 8'h00);
      send(OP_FSUB, RM_RUP, 32'h7, 32'h8, 5'd13, 32'h9, 5'd0, 0, RM_RUP);
      chk("after_bad_accept", 32'(acc_wait), 32'd0);
      drain();

      // FSQRT with writeback backpressure for 3 cycles
      wb_ready = 1'b0;
      hs0 = hs_cnt;
      send(OP_FSQRT, RM_RNE, 32'h4080_0000, 32'h0, 5'd12, 32'h4000_0000, 5'd0, 2, RM_RNE);
      n = 0;
      while (!wb_valid && n < 50) begin @(negedge clk); n++; end
      chk("bp_valid", 32'(wb_valid), 32'd1);
      repeat (3) begin
         chk("bp_hold_valid", 32'(wb_valid), 32'd1);
         chk("bp_hold_data", wb_data, 32'h4000_0000);
         chk("bp_hold_rd", 32'(wb_rd), 32'd12);
         chk("bp_not_ready", 32'(req_ready), 32'd0);
         chk("bp_no_start", 32'(fpu_start), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 wb_ready = 1'b1;
      drain();
      repeat (3) @(negedge clk);
      chk("bp_one_hs", 32'(hs_cnt - hs0), 32'd1);

      // CSR fflags write in the same cycle as an NX capture: write wins
      csr_wr(CSR_FFLAGS, 8'h04);
      send(OP_FADD, RM_RNE, 32'h1, 32'h1, 5'd14, 32'h2, f_nx, 0, RM_RNE);
      csr_we = 1'b1; csr_sel = CSR_FFLAGS; csr_wdata = 8'h00;
      @(posedge clk); #1 csr_we = 1'b0;
      @(negedge clk);
      chk("csr_beats_capture", 32'(fcsr_out[4:0]), 32'd0);
      drain();

      // reset while an FDIV is busy: abandoned, registers back to reset values at once
      csr_wr(CSR_FCSR, 8'h45);
      hs0 = hs_cnt;
      send(OP_FDIV, RM_RNE, 32'h3F80_0000, 32'h0, 5'd15, 32'h7F80_0000, f_dz, 30, RM_RNE);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_start", 32'(fpu_start), 32'd0);
      chk("rst_mid_fcsr", 32'(fcsr_out), 32'({3'b000, 5'b00000}));
      chk("rst_mid_wb", 32'(wb_valid), 32'd0);
      sb_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      repeat (35) @(negedge clk);
      chk("rst_mid_no_wb", 32'(hs_cnt - hs0), 32'd0);
      chk("rst_mid_no_flags", 32'(fcsr_out), 32'h00);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      send(OP_FADD, RM_RNE, 32'h3F80_0000, 32'h3F80_0000, 5'd16, 32'h4000_0000, 5'd0, 0, RM_RNE);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
